// File: rtl/blake2s_digest_buf_if.sv
// Digest buffer bus: hash-core byte stream in, host-paced byte pins out.
// The master side drives start/length, core bytes and host read strobes.
// The slave side is the buffer itself.
interface blake2s_digest_buf_if;
   logic       start_i;
   logic [5:0] nn_i;
   logic       h_v_i;
   logic [7:0] h_i;
   logic       rd_i;
   logic       hash_v_o;
   logic [7:0] hash_o;
   logic       done_o;
   logic       err_o;

   modport master (
      output start_i,
      output nn_i,
      output h_v_i,
      output h_i,
      output rd_i,
      input  hash_v_o,
      input  hash_o,
      input  done_o,
      input  err_o
   );

   modport slave (
      input  start_i,
      input  nn_i,
      input  h_v_i,
      input  h_i,
      input  rd_i,
      output hash_v_o,
      output hash_o,
      output done_o,
      output err_o
   );
endinterface

// File: rtl/blake2s_digest_buf.sv
// BLAKE2s digest output buffer.
// Captures nn digest bytes from the hash core (one per h_v strobe), then
// presents them one at a time to the host, advancing on each rd strobe.
// Protocol violations (bad length, unexpected core bytes) set a sticky error.
module blake2s_digest_buf #(
   parameter int unsigned NN_MAX = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   blake2s_digest_buf_if.slave  bus
);

   // Array index width; pointers themselves are 6 bits so they can reach NN_MAX.
   localparam int unsigned AW       = (NN_MAX > 1) ? $clog2(NN_MAX) : 1;
   localparam logic [5:0]  NN_MAX_6 = 6'(NN_MAX);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFill  = 2'd1,
      StDrain = 2'd2
   } state_t;

   state_t     r_state;
   logic [5:0] r_wp;
   logic [5:0] r_rp;
   logic [5:0] r_nn;
   logic [7:0] r_mem [NN_MAX];
   logic       r_hash_v;
   logic [7:0] r_hash;
   logic       r_done;
   logic       r_err;

   logic       w_nn_ok;
   logic [5:0] w_wp_inc;
   logic [5:0] w_rp_inc;
   logic [7:0] w_byte0;
   logic [7:0] w_rd_next;

   assign w_nn_ok  = (bus.nn_i != 6'd0) && (bus.nn_i <= NN_MAX_6);
   assign w_wp_inc = r_wp + 6'd1;
   assign w_rp_inc = r_rp + 6'd1;
   // For a one-byte digest, byte 0 is being written this very cycle.
   assign w_byte0   = (r_wp == 6'd0) ? bus.h_i : r_mem[0];
   assign w_rd_next = r_mem[w_rp_inc[AW-1:0]];

   // Control FSM, pointers, storage and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StIdle;
         r_wp     <= 6'd0;
         r_rp     <= 6'd0;
         r_nn     <= 6'd0;
         r_hash_v <= 1'b0;
         r_hash   <= 8'd0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.start_i) begin
            // Start overrides any concurrent h_v / rd.
            r_wp     <= 6'd0;
            r_rp     <= 6'd0;
            r_hash_v <= 1'b0;
            r_hash   <= 8'd0;
            if (w_nn_ok) begin
               r_nn    <= bus.nn_i;
               r_err   <= 1'b0;
               r_state <= StFill;
            end else begin
               r_err   <= 1'b1;
               r_state <= StIdle;
            end
         end else begin
            unique case (r_state)
               StIdle: begin
                  if (bus.h_v_i) begin
                     r_err <= 1'b1;
                  end
               end
               StFill: begin
                  if (bus.h_v_i) begin
                     r_mem[r_wp[AW-1:0]] <= bus.h_i;
                     r_wp                <= w_wp_inc;
                     if (w_wp_inc == r_nn) begin
                        r_state  <= StDrain;
                        r_hash_v <= 1'b1;
                        r_hash   <= w_byte0;
                     end
                  end
               end
               StDrain: begin
                  if (bus.h_v_i) begin
                     r_err <= 1'b1;
                  end
                  if (bus.rd_i) begin
                     r_rp <= w_rp_inc;
                     if (w_rp_inc == r_nn) begin
                        r_state  <= StIdle;
                        r_hash_v <= 1'b0;
                        r_hash   <= 8'd0;
                        r_done   <= 1'b1;
                     end else begin
                        r_hash <= w_rd_next;
                     end
                  end
               end
               default: begin
                  r_state <= StIdle;
               end
            endcase
         end
      end
   end

   assign bus.hash_v_o = r_hash_v;
   assign bus.hash_o   = r_hash;
   assign bus.done_o   = r_done;
   assign bus.err_o    = r_err;

endmodule

// File: tb/tb_blake2s_digest_buf.sv
// Directed bench for blake2s_digest_buf. Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point, well away from the edge.
module tb_blake2s_digest_buf;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   blake2s_digest_buf_if bus ();

   blake2s_digest_buf #(
      .NN_MAX (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [5:0] nn);
      bus.start_i = 1'b1;
      bus.nn_i    = nn;
      tick();
      bus.start_i = 1'b0;
      bus.nn_i    = 6'd0;
   endtask

   // Stream n bytes base, base+step, ... on consecutive cycles.
   task automatic fill(input int n, input logic [7:0] base, input logic [7:0] step);
      logic [7:0] b;
      b = base;
      for (int i = 0; i < n; i++) begin
         bus.h_v_i = 1'b1;
         bus.h_i   = b;
         tick();
         b = b + step;
      end
      bus.h_v_i = 1'b0;
      bus.h_i   = 8'd0;
   endtask

   task automatic check_outs(input string tag, input logic v, input logic [7:0] h,
                             input logic d, input logic e);
      check_val({tag, ".hash_v"}, 32'(bus.hash_v_o), 32'(v));
      check_val({tag, ".hash"},   32'(bus.hash_o),   32'(h));
      check_val({tag, ".done"},   32'(bus.done_o),   32'(d));
      check_val({tag, ".err"},    32'(bus.err_o),    32'(e));
   endtask

   initial begin
      logic [7:0] exp_b;
      n_checks    = 0;
      n_errors    = 0;
      reset       = 1'b1;
      bus.start_i = 1'b0;
      bus.nn_i    = 6'd0;
      bus.h_v_i   = 1'b0;
      bus.h_i     = 8'd0;
      bus.rd_i    = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check_outs("rst", 1'b0, 8'h00, 1'b0, 1'b0);
      check_val("rst.state", 32'(dut.r_state), 32'(ST_IDLE));

      // Full 32-byte digest, back-to-back reads.
      do_start(6'd32);
      check_val("full.state_fill", 32'(dut.r_state), 32'(ST_FILL));
      fill(32, 8'h00, 8'h01);
      check_outs("full.first", 1'b1, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         check_val("full.byte", 32'(bus.hash_o), 32'(i));
         check_val("full.v", 32'(bus.hash_v_o), 32'd1);
         bus.rd_i = 1'b1;
         tick();
      end
      bus.rd_i = 1'b0;
      check_outs("full.done", 1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      check_outs("full.after", 1'b0, 8'h00, 1'b0, 1'b0);

      // Single-byte digest.
      do_start(6'd1);
      fill(1, 8'hA5, 8'h00);
      check_outs("one.byte", 1'b1, 8'hA5, 1'b0, 1'b0);
      bus.rd_i = 1'b1;
      tick();
      bus.rd_i = 1'b0;
      check_outs("one.done", 1'b0, 8'h00, 1'b1, 1'b0);

      // Sparse host reads: rd every third cycle.
      do_start(6'd4);
      fill(4, 8'h11, 8'h11);
      exp_b = 8'h11;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 2; k++) begin
            check_outs("sparse.hold", 1'b1, exp_b, 1'b0, 1'b0);
            tick();
         end
         check_outs("sparse.pre_rd", 1'b1, exp_b, 1'b0, 1'b0);
         bus.rd_i = 1'b1;
         tick();
         bus.rd_i = 1'b0;
         exp_b = exp_b + 8'h11;
      end
      check_outs("sparse.done", 1'b0, 8'h00, 1'b1, 1'b0);

      // Protocol errors.
      do_start(6'd0);
      check_val("err.nn0", 32'(bus.err_o), 32'd1);
      check_val("err.nn0_state", 32'(dut.r_state), 32'(ST_IDLE));
      do_start(6'd4);
      check_val("err.cleared", 32'(bus.err_o), 32'd0);
      do_start(6'd33);
      check_val("err.nn33", 32'(bus.err_o), 32'd1);
      check_val("err.nn33_state", 32'(dut.r_state), 32'(ST_IDLE));
      do_start(6'd4);
      fill(4, 8'h50, 8'h01);
      check_outs("err.filled", 1'b1, 8'h50, 1'b0, 1'b0);
      fill(1, 8'h99, 8'h00);
      check_outs("err.extra", 1'b1, 8'h50, 1'b0, 1'b1);
      check_val("err.extra_state", 32'(dut.r_state), 32'(ST_DRAIN));
      bus.rd_i = 1'b1;
      tick();
      bus.rd_i = 1'b0;
      check_val("err.rd_after", 32'(bus.hash_o), 32'h51);

      // Start together with rd in mid-drain: start wins.
      bus.rd_i = 1'b1;
      do_start(6'd2);
      bus.rd_i = 1'b0;
      check_outs("simul", 1'b0, 8'h00, 1'b0, 1'b0);
      check_val("simul.state", 32'(dut.r_state), 32'(ST_FILL));
      check_val("simul.rp", 32'(dut.r_rp), 32'd0);
      fill(2, 8'h01, 8'h01);
      check_outs("simul.fill", 1'b1, 8'h01, 1'b0, 1'b0);

      // Reset in the middle of a drain.
      do_start(6'd8);
      fill(8, 8'h80, 8'h01);
      for (int i = 0; i < 3; i++) begin
         bus.rd_i = 1'b1;
         tick();
      end
      bus.rd_i = 1'b0;
      check_val("rstmid.pre", 32'(bus.hash_o), 32'h83);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_outs("rstmid", 1'b0, 8'h00, 1'b0, 1'b0);
      check_val("rstmid.state", 32'(dut.r_state), 32'(ST_IDLE));
      do_start(6'd8);
      fill(8, 8'hF0, 8'h01);
      exp_b = 8'hF0;
      for (int i = 0; i < 8; i++) begin
         check_outs("refill.byte", 1'b1, exp_b, 1'b0, 1'b0);
         bus.rd_i = 1'b1;
         tick();
         exp_b = exp_b + 8'h01;
      end
      bus.rd_i = 1'b0;
      check_outs("refill.done", 1'b0, 8'h00, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
